// File: rtl/multicycle_state_seq_if.sv
// Handshake and status bundle between the multicycle control path and the state sequencer.
// The sequencer owns the slave side; the master supplies the decoded IR fields and memory handshakes.
interface multicycle_state_seq_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       OpCode;
  logic [5:0]       func;
  logic             if_ready;
  logic             mem_ready;
  logic             stall;
  logic [2:0]       state;
  logic             retire;
  logic             halted;
  logic             illegal_op;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instr_cnt;

  modport master (
    output OpCode, func, if_ready, mem_ready, stall,
    input  state, retire, halted, illegal_op, cycle_cnt, instr_cnt
  );

  modport slave (
    input  OpCode, func, if_ready, mem_ready, stall,
    output state, retire, halted, illegal_op, cycle_cnt, instr_cnt
  );
endinterface

// File: rtl/multicycle_state_seq.sv
// Next-state sequencer for the multicycle CPU: walks IF/ID/EXE/MEM/WB, waits on memory
// handshakes, latches halt/illegal conditions and keeps cycle and retired-instruction counters.
module multicycle_state_seq #(
  parameter int CNT_W = 32
) (
  input  logic                  CLK,
  input  logic                  Reset,
  multicycle_state_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EXE1 = 3'b110,
    S_EXE2 = 3'b101,
    S_EXE3 = 3'b010,
    S_MEM  = 3'b011,
    S_WB1  = 3'b111,
    S_WB2  = 3'b100
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BLTZ  = 6'b000001;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  state_t           state_q, state_d;
  logic             retire_q, retire_d;
  logic             halted_q, halted_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] instr_q, instr_d;

  always_comb begin
    state_d   = state_q;
    retire_d  = 1'b0;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    cycle_d   = cycle_q;
    instr_d   = instr_q;

    if (halted_q) begin
      state_d = S_IF;
    end else if (!bus.stall) begin
      cycle_d = cycle_q + CNT_W'(1);
      case (state_q)
        S_IF: begin
          if (bus.if_ready) state_d = S_ID;
        end
        S_ID: begin
          // Undecoded opcodes fall through to IF as a NOP that does not retire.
          state_d = S_IF;
          case (bus.OpCode)
            OP_J, OP_JAL: retire_d = 1'b1;
            OP_RTYPE: begin
              case (bus.func)
                FN_JR: retire_d = 1'b1;
                FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_SLL: state_d = S_EXE1;
                default: illegal_d = 1'b1;
              endcase
            end
            OP_BEQ, OP_BNE, OP_BLTZ: state_d = S_EXE2;
            OP_LW, OP_SW: state_d = S_EXE3;
            OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: state_d = S_EXE1;
            OP_HALT: begin
              halted_d = 1'b1;
              retire_d = 1'b1;
            end
            default: illegal_d = 1'b1;
          endcase
        end
        S_EXE1: state_d = S_WB1;
        S_EXE2: begin
          state_d  = S_IF;
          retire_d = 1'b1;
        end
        S_EXE3: state_d = S_MEM;
        S_MEM: begin
          // Only lw needs the write-back cycle; anything else completes as a store.
          if (bus.mem_ready) begin
            if (bus.OpCode == OP_LW) begin
              state_d = S_WB2;
            end else begin
              state_d  = S_IF;
              retire_d = 1'b1;
            end
          end
        end
        S_WB1, S_WB2: begin
          state_d  = S_IF;
          retire_d = 1'b1;
        end
        default: state_d = S_IF;
      endcase
      if (retire_d) instr_d = instr_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_IF;
      retire_q  <= 1'b0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      cycle_q   <= '0;
      instr_q   <= '0;
    end else begin
      state_q   <= state_d;
      retire_q  <= retire_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
      cycle_q   <= cycle_d;
      instr_q   <= instr_d;
    end
  end

  assign bus.state      = state_q;
  assign bus.retire     = retire_q;
  assign bus.halted     = halted_q;
  assign bus.illegal_op = illegal_q;
  assign bus.cycle_cnt  = cycle_q;
  assign bus.instr_cnt  = instr_q;

endmodule

// File: tb/tb_multicycle_state_seq.sv
// Directed bench for multicycle_state_seq: a per-instruction vector table plus hand-written
// sequences for reset, memory wait, stall, halt, illegal opcode and counter wrap.
module tb_multicycle_state_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multicycle_state_seq_if #(.CNT_W(32)) bus ();
  multicycle_state_seq_if #(.CNT_W(4))  bus4 ();

  multicycle_state_seq #(.CNT_W(32)) dut  (.CLK(clk), .Reset(rst), .bus(bus.slave));
  multicycle_state_seq #(.CNT_W(4))  dut4 (.CLK(clk), .Reset(rst), .bus(bus4.slave));

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    int         cyc;
    int         ret;
    logic       ill;
  } vec_t;

  vec_t vecs [22];
  int   exp_trace [18] = '{0,1,6,7, 0,1,2,3,4, 0,1,2,3, 0,1,5, 0,1};

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [2:0] trace [$];
  int         retire_seen;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Runs one instruction from IF until the machine is back in IF, logging states and retires.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int mem_wait,
                           output int cycles);
    int waited = 0;
    cycles = 0;
    bus.OpCode   = op;
    bus.func     = fn;
    bus.if_ready = 1'b1;
    bus.stall    = 1'b0;
    do begin
      trace.push_back(bus.state);
      if (bus.state == 3'b011 && waited < mem_wait) begin
        bus.mem_ready = 1'b0;
        waited++;
      end else begin
        bus.mem_ready = 1'b1;
      end
      @(posedge clk); #1;
      cycles++;
      if (bus.retire) retire_seen++;
    end while (bus.state != 3'b000 && cycles < 40);
    bus.mem_ready = 1'b1;
    if (cycles >= 40) check("instr_timeout", 64'(cycles), 64'(0));
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int          cyc;
    int          mem_cnt;
    logic [63:0] c0, i0;

    vecs[0]  = '{6'b000000, 6'b100000, 4, 1, 1'b0};
    vecs[1]  = '{6'b000000, 6'b100010, 4, 1, 1'b0};
    vecs[2]  = '{6'b000000, 6'b100100, 4, 1, 1'b0};
    vecs[3]  = '{6'b000000, 6'b100101, 4, 1, 1'b0};
    vecs[4]  = '{6'b000000, 6'b101010, 4, 1, 1'b0};
    vecs[5]  = '{6'b000000, 6'b000000, 4, 1, 1'b0};
    vecs[6]  = '{6'b000000, 6'b001000, 2, 1, 1'b0};
    vecs[7]  = '{6'b000010, 6'b000000, 2, 1, 1'b0};
    vecs[8]  = '{6'b000011, 6'b000000, 2, 1, 1'b0};
    vecs[9]  = '{6'b000100, 6'b000000, 3, 1, 1'b0};
    vecs[10] = '{6'b000101, 6'b000000, 3, 1, 1'b0};
    vecs[11] = '{6'b000001, 6'b000000, 3, 1, 1'b0};
    vecs[12] = '{6'b100011, 6'b000000, 5, 1, 1'b0};
    vecs[13] = '{6'b101011, 6'b000000, 4, 1, 1'b0};
    vecs[14] = '{6'b001001, 6'b000000, 4, 1, 1'b0};
    vecs[15] = '{6'b001100, 6'b000000, 4, 1, 1'b0};
    vecs[16] = '{6'b001101, 6'b000000, 4, 1, 1'b0};
    vecs[17] = '{6'b001110, 6'b000000, 4, 1, 1'b0};
    vecs[18] = '{6'b001010, 6'b000000, 4, 1, 1'b0};
    vecs[19] = '{6'b000000, 6'b000001, 2, 0, 1'b1};
    vecs[20] = '{6'b111000, 6'b000000, 2, 0, 1'b1};
    vecs[21] = '{6'b001000, 6'b000000, 2, 0, 1'b1};

    bus.OpCode = 6'd0;  bus.func = 6'd0;  bus.if_ready = 1'b0;
    bus.mem_ready = 1'b1; bus.stall = 1'b0;
    bus4.OpCode = 6'b001001; bus4.func = 6'd0; bus4.if_ready = 1'b0;
    bus4.mem_ready = 1'b1;   bus4.stall = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_state",   64'(bus.state), 64'(0));
    check("rst_retire",  64'(bus.retire), 64'(0));
    check("rst_halted",  64'(bus.halted), 64'(0));
    check("rst_illegal", 64'(bus.illegal_op), 64'(0));
    check("rst_cycle",   64'(bus.cycle_cnt), 64'(0));
    check("rst_instr",   64'(bus.instr_cnt), 64'(0));
    rst = 1'b0;

    // Narrow counters: 17 addiu = 68 cycles
    bus4.if_ready = 1'b1;
    repeat (68) @(posedge clk);
    #1;
    bus4.if_ready = 1'b0;
    check("wrap_instr", 64'(bus4.instr_cnt), 64'(1));
    check("wrap_cycle", 64'(bus4.cycle_cnt), 64'(4));
    check("wrap_state", 64'(bus4.state), 64'(0));

    // Reset mid-EXE1, then add, lw, sw, beq, j
    bus.OpCode = 6'b000000; bus.func = 6'b100000; bus.if_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_exe1", 64'(bus.state), 64'(6));
    rst = 1'b1;
    #2;
    check("async_rst_state",  64'(bus.state), 64'(0));
    check("async_rst_cycle",  64'(bus.cycle_cnt), 64'(0));
    check("async_rst_retire", 64'(bus.retire), 64'(0));
    rst = 1'b0;
    trace.delete();
    retire_seen = 0;
    run_instr(6'b000000, 6'b100000, 0, cyc);
    run_instr(6'b100011, 6'b000000, 0, cyc);
    run_instr(6'b101011, 6'b000000, 0, cyc);
    run_instr(6'b000100, 6'b000000, 0, cyc);
    run_instr(6'b000010, 6'b000000, 0, cyc);
    check("seq_trace_len", 64'(trace.size()), 64'(18));
    for (int i = 0; i < 18 && i < trace.size(); i++)
      check($sformatf("seq_trace[%0d]", i), 64'(trace[i]), 64'(exp_trace[i]));
    check("seq_instr",   64'(bus.instr_cnt), 64'(5));
    check("seq_cycle",   64'(bus.cycle_cnt), 64'(18));
    check("seq_retires", 64'(retire_seen), 64'(5));

    // One record per instruction class
    for (int i = 0; i < 22; i++) begin
      c0 = 64'(bus.cycle_cnt);
      i0 = 64'(bus.instr_cnt);
      retire_seen = 0;
      run_instr(vecs[i].op, vecs[i].fn, 0, cyc);
      $display("vec %0d op=%b fn=%b cycles=%0d retires=%0d illegal=%0d",
               i, vecs[i].op, vecs[i].fn, cyc, retire_seen, bus.illegal_op);
      check($sformatf("vec%0d_cycles", i),  64'(cyc), 64'(vecs[i].cyc));
      check($sformatf("vec%0d_retire", i),  64'(retire_seen), 64'(vecs[i].ret));
      check($sformatf("vec%0d_instr", i),   64'(bus.instr_cnt) - i0, 64'(vecs[i].ret));
      check($sformatf("vec%0d_cyccnt", i),  64'(bus.cycle_cnt) - c0, 64'(vecs[i].cyc));
      check($sformatf("vec%0d_illegal", i), 64'(bus.illegal_op), 64'(vecs[i].ill));
    end

    // lw with three wait cycles on mem_ready
    pulse_reset();
    trace.delete();
    retire_seen = 0;
    c0 = 64'(bus.cycle_cnt);
    i0 = 64'(bus.instr_cnt);
    run_instr(6'b100011, 6'b000000, 3, cyc);
    mem_cnt = 0;
    foreach (trace[k]) if (trace[k] == 3'b011) mem_cnt++;
    check("lwwait_cycles", 64'(cyc), 64'(8));
    check("lwwait_memcnt", 64'(mem_cnt), 64'(4));
    if (trace.size() == 8) check("lwwait_wb2", 64'(trace[7]), 64'(4));
    else check("lwwait_trace_len", 64'(trace.size()), 64'(8));
    check("lwwait_cyccnt", 64'(bus.cycle_cnt) - c0, 64'(8));
    check("lwwait_instr",  64'(bus.instr_cnt) - i0, 64'(1));
    check("lwwait_retire", 64'(retire_seen), 64'(1));

    // sw stalled 5 cycles in EXE3, then stall+mem_ready together in MEM
    bus.OpCode = 6'b101011; bus.if_ready = 1'b1; bus.mem_ready = 1'b1; bus.stall = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("stall_exe3", 64'(bus.state), 64'(2));
    c0 = 64'(bus.cycle_cnt);
    i0 = 64'(bus.instr_cnt);
    bus.stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      $display("stall cycle %0d state=%0d cycle_cnt=%0d", k, bus.state, bus.cycle_cnt);
      check($sformatf("stall%0d_state", k),  64'(bus.state), 64'(2));
      check($sformatf("stall%0d_cycle", k),  64'(bus.cycle_cnt), c0);
      check($sformatf("stall%0d_retire", k), 64'(bus.retire), 64'(0));
    end
    bus.stall = 1'b0;
    @(posedge clk); #1;
    check("stall_mem", 64'(bus.state), 64'(3));
    check("stall_mem_cycle", 64'(bus.cycle_cnt), c0 + 1);
    bus.stall = 1'b1;
    @(posedge clk); #1;
    check("stall_wins_mem", 64'(bus.state), 64'(3));
    check("stall_wins_retire", 64'(bus.retire), 64'(0));
    bus.stall = 1'b0;
    @(posedge clk); #1;
    check("stall_sw_done", 64'(bus.state), 64'(0));
    check("stall_sw_retire", 64'(bus.retire), 64'(1));
    check("stall_sw_cycle", 64'(bus.cycle_cnt), c0 + 2);
    check("stall_sw_instr", 64'(bus.instr_cnt), i0 + 1);

    // Illegal opcode then a clean ori
    pulse_reset();
    i0 = 64'(bus.instr_cnt);
    retire_seen = 0;
    run_instr(6'b111000, 6'b000000, 0, cyc);
    check("ill_cycles",  64'(cyc), 64'(2));
    check("ill_flag",    64'(bus.illegal_op), 64'(1));
    check("ill_retire",  64'(retire_seen), 64'(0));
    check("ill_instr",   64'(bus.instr_cnt), i0);
    run_instr(6'b001101, 6'b000000, 0, cyc);
    check("ori_cycles",  64'(cyc), 64'(4));
    check("ori_retire",  64'(retire_seen), 64'(1));
    check("ori_instr",   64'(bus.instr_cnt), i0 + 1);

    // Halt, then confirm everything is frozen until reset
    i0 = 64'(bus.instr_cnt);
    retire_seen = 0;
    run_instr(6'b111111, 6'b000000, 0, cyc);
    check("halt_cycles", 64'(cyc), 64'(2));
    check("halt_flag",   64'(bus.halted), 64'(1));
    check("halt_instr",  64'(bus.instr_cnt), i0 + 1);
    check("halt_retire", 64'(retire_seen), 64'(1));
    c0 = 64'(bus.cycle_cnt);
    i0 = 64'(bus.instr_cnt);
    bus.OpCode = 6'b000000; bus.func = 6'b100000;
    for (int k = 0; k < 10; k++) begin
      bus.if_ready = ~bus.if_ready;
      @(posedge clk); #1;
      check($sformatf("halted%0d_state", k), 64'(bus.state), 64'(0));
      check($sformatf("halted%0d_cycle", k), 64'(bus.cycle_cnt), c0);
      check($sformatf("halted%0d_instr", k), 64'(bus.instr_cnt), i0);
    end
    check("halted_retire", 64'(bus.retire), 64'(0));
    rst = 1'b1;
    #2;
    check("halt_rst_halted",  64'(bus.halted), 64'(0));
    check("halt_rst_illegal", 64'(bus.illegal_op), 64'(0));
    check("halt_rst_cycle",   64'(bus.cycle_cnt), 64'(0));
    check("halt_rst_instr",   64'(bus.instr_cnt), 64'(0));
    check("halt_rst_state",   64'(bus.state), 64'(0));
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_state_seq.md
Name: multicycle_state_seq

Overview:
- Next-state sequencer for the multicycle CPU. It produces the 3-bit `state` consumed by the control-signal decoder.
- Walks each instruction through IF/ID/EXE/MEM/WB using the instruction opcode and funct fields.
- Stalls on the instruction-memory and data-memory ready handshakes.
- Latches halt and illegal-opcode conditions.
- Keeps cycle and retired-instruction counters for the top-level debug display.

Parameters:
- CNT_W, 32, width of the `cycle_cnt` and `instr_cnt` counters.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- OpCode  input  6  opcode of the instruction held in IR; valid from ID onward.
- func  input  6  funct field of the instruction in IR.
- if_ready  input  1  instruction memory has valid data this cycle.
- mem_ready  input  1  data memory has completed the access this cycle.
- stall  input  1  external freeze; holds state and both counters.
- state  output  3  current state: IF=000, ID=001, EXE1=110, EXE2=101, EXE3=010, MEM=011, WB1=111, WB2=100.
- retire  output  1  one-cycle pulse on the edge that returns the machine to IF after a completed instruction.
- halted  output  1  sticky; set by the halt opcode 111111.
- illegal_op  output  1  sticky; set by an undecoded opcode or funct.
- cycle_cnt  output  CNT_W  count of clocks that were not halted and not stalled.
- instr_cnt  output  CNT_W  count of retired instructions.

Behaviour:
- Reset (async, active-high) forces: `state`=IF, `retire`=0, `halted`=0, `illegal_op`=0, `cycle_cnt`=0, `instr_cnt`=0. Reset asserted mid-instruction abandons that instruction; no retire is generated.
- All outputs are registered.
- Priority per rising edge: Reset > halted > stall > normal transition.
  - With `halted`=1: `state` stays IF, counters freeze, `retire`=0. Only Reset clears `halted`.
  - With `stall`=1: `state` and counters hold, `retire`=0.
- Transitions:
  - IF: go to ID when `if_ready`=1; otherwise stay in IF.
  - ID, routed by opcode/funct:
    - j 000010, jal 000011, or jr (000000 with func 001000) → IF, retire.
    - beq 000100, bne 000101, bltz 000001 → EXE2.
    - lw 100011, sw 101011 → EXE3.
    - R-type (000000 with func 100000/100010/100100/100101/101010/000000) → EXE1.
    - addiu 001001, andi 001100, ori 001101, xori 001110, slti 001010 → EXE1.
    - halt 111111 → IF, set `halted`, retire (halt counts as retired).
    - Any other opcode, or 000000 with any other funct → IF, set `illegal_op`, no retire. The instruction is treated as a NOP.
  - EXE1 → WB1.
  - EXE2 → IF, retire.
  - EXE3 → MEM.
  - MEM:
    - Holds while `mem_ready`=0.
    - When `mem_ready`=1: lw → WB2; sw → IF, retire.
  - WB1 → IF, retire.
  - WB2 → IF, retire.
- Cycles per instruction with ready inputs high: j/jal/jr/halt 2; branch 3; R-type/I-type ALU 4; sw 4; lw 5. Each wait cycle on `if_ready` or `mem_ready` adds 1.
- `retire` is high during the first cycle of the following IF, one cycle only. `instr_cnt` increments on the same edge.
- `cycle_cnt` increments on every edge where the machine is not halted and `stall`=0. Wait cycles are counted.
- Both counters wrap modulo 2^CNT_W; no saturation and no overflow flag.
- Unreachable state encodings do not exist: all 8 codes are legal.
- The opcode is sampled only in ID and MEM. OpCode changes during EXE/WB have no effect.
- Simultaneous `stall`=1 and `mem_ready`=1 in MEM: stall wins; MEM is re-evaluated on the next unstalled edge.

Test Plan:
- Reset pulse mid-EXE1, then the sequence add (000000/100000), lw, sw, beq, j, all ready inputs high → states 000,001,110,111 | 000,001,010,011,100 | 000,001,010,011 | 000,001,101 | 000,001. Result: `instr_cnt`=5, `cycle_cnt`=18, 5 `retire` pulses.
- lw with `mem_ready` low for 3 cycles → MEM held 4 cycles, then WB2. Total 8 cycles; `cycle_cnt` +8, `instr_cnt` +1.
- Halt 111111 in ID → `state`=IF, `halted`=1, `instr_cnt` +1. Toggling `if_ready` for 10 cycles leaves `state`, `cycle_cnt` and `instr_cnt` unchanged. Asserting Reset clears everything to 0.
- OpCode 111000 in ID → back to IF, `illegal_op`=1, no `retire`, `instr_cnt` unchanged. A following ori completes normally in 4 cycles.
- `stall` held 5 cycles during EXE3 with `mem_ready`=1 → `state` stays 010 and `cycle_cnt` frozen for those 5 cycles, then normal sw completion.
- CNT_W=4 with 17 ALU instructions → `instr_cnt` wraps to 1 and `cycle_cnt` wraps to 68 mod 16 = 4.
